// File: rtl/game_pkg.sv
// Purpose : shared types and constants for the runner-game flow controller.
// Latency : n/a (types only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [2:0] {
    S_COUNT  = 3'd0,
    S_LOGO   = 3'd1,
    S_PLAYER = 3'd2,
    S_PLAY   = 3'd3,
    S_HIT    = 3'd4,
    S_OVER   = 3'd5
  } game_state_t;

  // Game-over layer offset while the layer is hidden.
  localparam int unsigned OFFSCREEN = 700;

endpackage

// File: rtl/game_if.sv
// Purpose : bundles the controller's frame/input pulses and layer/score outputs.
// Latency : n/a (wires only).
// Backpressure: none; pulses are one clk wide and are never stalled.
// master = environment (drives tick/buttons/hits), slave = game_controller.
interface game_if #(
  parameter int NUM_LANES = 3,
  parameter int NUM_COIN  = 3,
  parameter int NUM_FATAL = 4,
  parameter int SCORE_W   = 16,
  parameter int LIVES     = 3
);
  import game_pkg::*;

  localparam int LANE_W  = $clog2(NUM_LANES);
  localparam int LIVES_W = $clog2(LIVES + 1);

  logic                 frame_tick;
  logic                 btn_left;
  logic                 btn_right;
  logic                 restart;
  logic [NUM_COIN-1:0]  coin_hit;
  logic [NUM_FATAL-1:0] fatal_hit;

  game_state_t          state;
  logic [11:0]          logo_voffset;
  logic [11:0]          player_voffset;
  logic [11:0]          player_hoffset;
  logic [LANE_W-1:0]    player_lane;
  logic                 spawn_en;
  logic                 invuln;
  logic [11:0]          over_voffset;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   high_score;
  logic [LIVES_W-1:0]   lives;

  modport master (
    output frame_tick, btn_left, btn_right, restart, coin_hit, fatal_hit,
    input  state, logo_voffset, player_voffset, player_hoffset, player_lane,
           spawn_en, invuln, over_voffset, score, high_score, lives
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, restart, coin_hit, fatal_hit,
    output state, logo_voffset, player_voffset, player_hoffset, player_lane,
           spawn_en, invuln, over_voffset, score, high_score, lives
  );

endinterface

// File: rtl/game_lane_tracker.sv
// Purpose : button edge detect, clamped lane position and signed pixel offset.
// Latency : lane/hoffset update 1 clk after a button rising edge.
// Backpressure: none; edges outside en are dropped, not queued.
// Ports: clk/rst, clr (recentre), en (moves allowed), btn_left/btn_right (levels),
//        lane (current lane), hoffset (signed (lane-centre)*LANE_PITCH).
module lane_tracker #(
  parameter int NUM_LANES  = 3,
  parameter int LANE_PITCH = 100,
  parameter int LANE_W     = $clog2(NUM_LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              btn_left,
  input  logic              btn_right,
  output logic [LANE_W-1:0] lane,
  output logic [11:0]       hoffset
);

  localparam int CENTRE = NUM_LANES / 2;
  localparam int LAST   = NUM_LANES - 1;

  logic              left_prev_q, right_prev_q;
  logic              left_rise, right_rise;
  logic [LANE_W-1:0] lane_d, lane_q;
  logic [11:0]       hoffset_d, hoffset_q;
  logic signed [31:0] offset;

  always_comb begin
    left_rise  = btn_left  & ~left_prev_q;
    right_rise = btn_right & ~right_prev_q;
    lane_d     = lane_q;
    if (clr) begin
      lane_d = LANE_W'(CENTRE);
    end else if (en && (left_rise ^ right_rise)) begin
      // Simultaneous edges cancel; a single edge moves one lane, clamped.
      if (right_rise && (lane_q != LANE_W'(LAST))) lane_d = lane_q + 1'b1;
      else if (left_rise && (lane_q != '0))         lane_d = lane_q - 1'b1;
    end
    offset    = (signed'(32'(lane_d)) - CENTRE) * LANE_PITCH;
    hoffset_d = offset[11:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      lane_q       <= LANE_W'(CENTRE);
      hoffset_q    <= '0;
    end else begin
      left_prev_q  <= btn_left;
      right_prev_q <= btn_right;
      lane_q       <= lane_d;
      hoffset_q    <= hoffset_d;
    end
  end

  assign lane    = lane_q;
  assign hoffset = hoffset_q;

endmodule

// File: rtl/game_controller.sv
// Purpose : runner-game flow FSM (countdown, logo fade, player fade, play/hit, over),
//           score, high score, lives and lane position.
// Latency : every output registered, 1 clk after its cause.
// Backpressure: none; frame_tick paces fades/timers, hits/coins act every clk.
// Ports: clk, rst (sync, active-high), bus (game_if.slave: inputs tick/buttons/
//        restart/coin_hit/fatal_hit, outputs state/layer offsets/lane/score/lives).
module game_controller #(
  parameter int NUM_LANES        = 3,
  parameter int LANE_PITCH       = 100,
  parameter int NUM_COIN         = 3,
  parameter int NUM_FATAL        = 4,
  parameter int SCORE_W          = 16,
  parameter int LIVES            = 3,
  parameter int COUNTDOWN_FRAMES = 5,
  parameter int LOGO_STEP        = 30,
  parameter int LOGO_END         = 640,
  parameter int PLAYER_START     = 180,
  parameter int PLAYER_STEP      = 20,
  parameter int PLAYER_END       = 50,
  parameter int INVULN_FRAMES    = 60,
  parameter int OFFSCREEN        = int'(game_pkg::OFFSCREEN)
) (
  input  logic   clk,
  input  logic   rst,
  game_if.slave  bus
);
  import game_pkg::*;

  localparam int LANE_W  = $clog2(NUM_LANES);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int TMR_W   = 16;

  game_state_t        state_d, state_q;
  logic [TMR_W-1:0]   timer_d, timer_q;   // countdown in S_COUNT, invuln window in S_HIT
  logic [11:0]        logo_d, logo_q;
  logic [11:0]        player_d, player_q;
  logic [SCORE_W-1:0] score_d, score_q;
  logic [SCORE_W-1:0] high_d, high_q;
  logic [LIVES_W-1:0] lives_d, lives_q;
  logic               spawn_d, spawn_q;
  logic               invuln_d, invuln_q;
  logic [11:0]        over_d, over_q;
  logic [SCORE_W:0]   score_sum;
  logic               playing;
  logic               new_game;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    logo_d    = logo_q;
    player_d  = player_q;
    score_d   = score_q;
    high_d    = high_q;
    lives_d   = lives_q;
    new_game  = 1'b0;
    playing   = (state_q == S_PLAY) || (state_q == S_HIT);
    score_sum = {1'b0, score_q} + (SCORE_W+1)'($countones(bus.coin_hit));

    if (playing) score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    case (state_q)
      S_COUNT: if (bus.frame_tick) begin
        if (timer_q != '0)       timer_d = timer_q - 1'b1;
        if (timer_q <= TMR_W'(1)) state_d = S_LOGO;
      end
      S_LOGO: if (bus.frame_tick) begin
        // Leave on the tick whose step reaches the end offset.
        if (logo_q < 12'(LOGO_END)) begin
          logo_d = logo_q + 12'(LOGO_STEP);
          if (logo_d >= 12'(LOGO_END)) state_d = S_PLAYER;
        end else begin
          state_d = S_PLAYER;
        end
      end
      S_PLAYER: if (bus.frame_tick) begin
        if ({1'b0, player_q} >= 13'(PLAYER_END + PLAYER_STEP)) player_d = player_q - 12'(PLAYER_STEP);
        else                                                    player_d = 12'(PLAYER_END);
        if (player_d == 12'(PLAYER_END)) state_d = S_PLAY;
      end
      S_PLAY: if (|bus.fatal_hit) begin
        if (lives_q <= LIVES_W'(1)) begin
          lives_d = '0;
          state_d = S_OVER;
        end else begin
          lives_d = lives_q - 1'b1;
          timer_d = TMR_W'(INVULN_FRAMES);
          state_d = S_HIT;
        end
      end
      S_HIT: if (bus.frame_tick) begin
        if (timer_q != '0)       timer_d = timer_q - 1'b1;
        if (timer_q <= TMR_W'(1)) state_d = S_PLAY;
      end
      S_OVER: if (bus.frame_tick && bus.restart) new_game = 1'b1;
      default: new_game = 1'b1;
    endcase

    // Capture against score_d so coins on the killing clk are included.
    if ((state_d == S_OVER) && (state_q != S_OVER) && (score_d > high_q)) high_d = score_d;

    if (new_game) begin
      state_d  = S_COUNT;
      timer_d  = TMR_W'(COUNTDOWN_FRAMES);
      logo_d   = '0;
      player_d = 12'(PLAYER_START);
      score_d  = '0;
      lives_d  = LIVES_W'(LIVES);
    end

    spawn_d  = (state_d == S_PLAY) || (state_d == S_HIT);
    invuln_d = (state_d == S_HIT);
    over_d   = (state_d == S_OVER) ? 12'd0 : 12'(OFFSCREEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_COUNT;
      timer_q  <= TMR_W'(COUNTDOWN_FRAMES);
      logo_q   <= '0;
      player_q <= 12'(PLAYER_START);
      score_q  <= '0;
      high_q   <= '0;
      lives_q  <= LIVES_W'(LIVES);
      spawn_q  <= 1'b0;
      invuln_q <= 1'b0;
      over_q   <= 12'(OFFSCREEN);
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      logo_q   <= logo_d;
      player_q <= player_d;
      score_q  <= score_d;
      high_q   <= high_d;
      lives_q  <= lives_d;
      spawn_q  <= spawn_d;
      invuln_q <= invuln_d;
      over_q   <= over_d;
    end
  end

  lane_tracker #(
    .NUM_LANES  (NUM_LANES),
    .LANE_PITCH (LANE_PITCH),
    .LANE_W     (LANE_W)
  ) u_lane (
    .clk       (clk),
    .rst       (rst),
    .clr       (new_game),
    .en        (playing),
    .btn_left  (bus.btn_left),
    .btn_right (bus.btn_right),
    .lane      (bus.player_lane),
    .hoffset   (bus.player_hoffset)
  );

  assign bus.state          = state_q;
  assign bus.logo_voffset   = logo_q;
  assign bus.player_voffset = player_q;
  assign bus.spawn_en       = spawn_q;
  assign bus.invuln         = invuln_q;
  assign bus.over_voffset   = over_q;
  assign bus.score          = score_q;
  assign bus.high_score     = high_q;
  assign bus.lives          = lives_q;

endmodule
